hazard_stall_controller: RTL and testbench

Pipeline hazard and stall sequencer for the 5-stage processor. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers and drives their write/flush controls, the PC write enable and the `hazardMux` select of `muxControle`. It handles three cases: load-use stalls, flushes on a branch taken in MEM, and multi-cycle freezes while the data memory completes. It also keeps saturating stall and flush counters and raises a sticky timeout flag on a hung memory access.

---
 rtl/hazard_stall_controller_if.sv | 44 ++++
 rtl/hazard_stall_controller.sv | 145 ++++++++++++++
 tb/tb_hazard_stall_controller.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_controller_if.sv
// rtl/hazard_stall_controller_if.sv - hazard/stall controller pipeline-side signal bundle
//
// Purpose: groups the hazard inputs sampled from the pipeline registers and the
// stall/flush controls returned to them.
// Ports (via modports):
//   slave  - the controller: receives hazard inputs, drives controls and counters.
//   master - the pipeline/bench: drives hazard inputs, receives controls and counters.
interface hazard_stall_controller_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ifid_rs;
    logic [4:0]       ifid_rt;
    logic             idex_mem_read;
    logic [4:0]       idex_rt;
    logic             exmem_mem_access;
    logic             mem_ready;
    logic             pcsrc;
    logic             pc_write;
    logic             ifid_write;
    logic             pipe_hold;
    logic             hazard_mux;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport slave (
        input  ifid_rs, ifid_rt, idex_mem_read, idex_rt,
               exmem_mem_access, mem_ready, pcsrc,
        output pc_write, ifid_write, pipe_hold, hazard_mux,
               ifid_flush, idex_flush, exmem_flush,
               mem_timeout, stall_cycles, flush_count
    );

    modport master (
        output ifid_rs, ifid_rt, idex_mem_read, idex_rt,
               exmem_mem_access, mem_ready, pcsrc,
        input  pc_write, ifid_write, pipe_hold, hazard_mux,
               ifid_flush, idex_flush, exmem_flush,
               mem_timeout, stall_cycles, flush_count
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - load-use / branch-flush / memory-freeze sequencer
//
// Purpose: drives PC/IF/ID write enables, pipeline hold, bubble select and flushes
// for a 5-stage pipeline; counts stall cycles and flush events (saturating) and
// raises a sticky timeout when a memory access stays unready too long.
// Ports:
//   clock - rising-edge clock
//   reset - synchronous, active-high; forces a fully frozen/flushed output set
//   bus   - hazard_stall_controller_if.slave: hazard inputs, controls, counters
module hazard_stall_controller #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    hazard_stall_controller_if.slave  bus
);
    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } stateT;

    stateT             stateQ, stateD;
    logic [WCNT_W-1:0] wcntQ, wcntD;
    logic              memTimeoutQ, memTimeoutD;
    logic [CNT_W-1:0]  stallCyclesQ;
    logic [CNT_W-1:0]  flushCountQ;

    logic loadUse, memStall;
    logic freeze, doFlush, doBubble;
    logic pcWrite;

    assign loadUse  = bus.idex_mem_read && (bus.idex_rt != 5'd0) &&
                      ((bus.idex_rt == bus.ifid_rs) || (bus.idex_rt == bus.ifid_rt));
    assign memStall = bus.exmem_mem_access && !bus.mem_ready;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            stateQ      <= RUN;
            wcntQ       <= '0;
            memTimeoutQ <= 1'b0;
        end else begin
            stateQ      <= stateD;
            wcntQ       <= wcntD;
            memTimeoutQ <= memTimeoutD;
        end
    end

    // Next-state logic
    always_comb begin
        stateD      = stateQ;
        wcntD       = wcntQ;
        memTimeoutD = memTimeoutQ;
        case (stateQ)
            RUN: begin
                if (memStall) begin
                    stateD = MEM_WAIT;
                    wcntD  = WCNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (!bus.mem_ready) begin
                    if (wcntQ == WCNT_W'(TIMEOUT)) begin
                        stateD      = ERROR;
                        memTimeoutD = 1'b1;
                    end else begin
                        wcntD = wcntQ + WCNT_W'(1);
                    end
                end else begin
                    stateD = RUN;
                    wcntD  = '0;
                end
            end
            ERROR: begin
                stateD = ERROR;
            end
            default: begin
                stateD = RUN;
                wcntD  = '0;
            end
        endcase
    end

    // Output decode. In MEM_WAIT only mem_ready matters for the freeze: EX/MEM is
    // held, so the access itself is still pending regardless of the sampled flag.
    // A release cycle falls through to the branch/load-use priority chain.
    always_comb begin
        freeze   = 1'b0;
        doFlush  = 1'b0;
        doBubble = 1'b0;
        case (stateQ)
            RUN: begin
                if (memStall)       freeze   = 1'b1;
                else if (bus.pcsrc) doFlush  = 1'b1;
                else if (loadUse)   doBubble = 1'b1;
            end
            MEM_WAIT: begin
                if (!bus.mem_ready) freeze   = 1'b1;
                else if (bus.pcsrc) doFlush  = 1'b1;
                else if (loadUse)   doBubble = 1'b1;
            end
            default: freeze = 1'b1;
        endcase

        if (reset) begin
            pcWrite         = 1'b0;
            bus.ifid_write  = 1'b0;
            bus.pipe_hold   = 1'b1;
            bus.hazard_mux  = 1'b1;
            bus.ifid_flush  = 1'b1;
            bus.idex_flush  = 1'b1;
            bus.exmem_flush = 1'b1;
        end else begin
            pcWrite         = !(freeze || doBubble);
            bus.ifid_write  = !(freeze || doBubble);
            bus.pipe_hold   = freeze;
            bus.hazard_mux  = doBubble;
            bus.ifid_flush  = doFlush;
            bus.idex_flush  = doFlush;
            bus.exmem_flush = doFlush;
        end
        bus.pc_write = pcWrite;
    end

    // Saturating performance counters
    always_ff @(posedge clock) begin
        if (reset) begin
            stallCyclesQ <= '0;
            flushCountQ  <= '0;
        end else begin
            if (!pcWrite && (stallCyclesQ != {CNT_W{1'b1}}))
                stallCyclesQ <= stallCyclesQ + CNT_W'(1);
            if (doFlush && (flushCountQ != {CNT_W{1'b1}}))
                flushCountQ <= flushCountQ + CNT_W'(1);
        end
    end

    assign bus.mem_timeout  = memTimeoutQ;
    assign bus.stall_cycles = stallCyclesQ;
    assign bus.flush_count  = flushCountQ;
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - randomized + directed check of hazard_stall_controller
module tb_hazard_stall_controller;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic clock;
    logic reset;

    hazard_stall_controller_if #(.CNT_W(CNT_W)) hif ();

    hazard_stall_controller #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (hif.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the pipeline is "frozen" while an access is pending or
    // after a hung access; frozenRun counts consecutive frozen cycles of the
    // current access, and the access hangs once that reaches TIMEOUT+1.
    bit mValid    = 0;
    bit mHung     = 0;
    int frozenRun = 0;
    int mStall    = 0;
    int mFlush    = 0;
    bit mTimeout  = 0;

    function automatic bit modelLoadUse();
        return hif.idex_mem_read && (hif.idex_rt != 0) &&
               ((hif.idex_rt == hif.ifid_rs) || (hif.idex_rt == hif.ifid_rt));
    endfunction

    function automatic bit modelFrozen();
        if (mHung) return 1'b1;
        if (frozenRun > 0) return !hif.mem_ready;
        return hif.exmem_mem_access && !hif.mem_ready;
    endfunction

    always @(posedge clock) begin
        bit fr, bub, fl;
        if (reset) begin
            mValid    = 1;
            mHung     = 0;
            frozenRun = 0;
            mStall    = 0;
            mFlush    = 0;
            mTimeout  = 0;
        end else if (mValid) begin
            fr  = modelFrozen();
            fl  = !fr && hif.pcsrc;
            bub = !fr && !hif.pcsrc && modelLoadUse();
            if ((fr || bub) && mStall < CMAX) mStall++;
            if (fl && mFlush < CMAX) mFlush++;
            if (!mHung) begin
                if (fr) begin
                    frozenRun++;
                    if (frozenRun == TIMEOUT + 1) begin
                        mHung    = 1;
                        mTimeout = 1;
                    end
                end else begin
                    frozenRun = 0;
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clock) begin
        logic [6:0] expCtrl, actCtrl;
        bit fr, bub, fl;
        if (mValid) begin
            if (reset) begin
                expCtrl = 7'b0011111;
            end else begin
                fr  = modelFrozen();
                fl  = !fr && hif.pcsrc;
                bub = !fr && !hif.pcsrc && modelLoadUse();
                expCtrl = {!(fr || bub), !(fr || bub), fr, bub, fl, fl, fl};
            end
            actCtrl = {hif.pc_write, hif.ifid_write, hif.pipe_hold, hif.hazard_mux,
                       hif.ifid_flush, hif.idex_flush, hif.exmem_flush};
            check("ctrl", int'(actCtrl), int'(expCtrl));
            check("stall_cycles", int'(hif.stall_cycles), mStall);
            check("flush_count", int'(hif.flush_count), mFlush);
            check("mem_timeout", int'(hif.mem_timeout), int'(mTimeout));
        end
    end

    task automatic clearInputs();
        hif.ifid_rs          = 5'd0;
        hif.ifid_rt          = 5'd0;
        hif.idex_mem_read    = 1'b0;
        hif.idex_rt          = 5'd0;
        hif.exmem_mem_access = 1'b0;
        hif.mem_ready        = 1'b1;
        hif.pcsrc            = 1'b0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        clearInputs();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int busyLeft;
        reset = 1'b1;
        clearInputs();
        step();
        step();
        reset = 1'b0;

        // Reset state
        @(negedge clock);
        check("reset_stall", int'(hif.stall_cycles), 0);
        check("reset_pc_write", int'(hif.pc_write), 1);

        // Load-use: one bubble cycle
        doReset();
        hif.idex_mem_read = 1'b1; hif.idex_rt = 5'd5; hif.ifid_rs = 5'd5;
        @(negedge clock);
        check("lu_pc_write", int'(hif.pc_write), 0);
        check("lu_hazard_mux", int'(hif.hazard_mux), 1);
        step();
        clearInputs();
        @(negedge clock);
        check("lu_after_pc_write", int'(hif.pc_write), 1);
        check("lu_stall_cycles", int'(hif.stall_cycles), 1);
        // rt = 0 never stalls
        hif.idex_mem_read = 1'b1;
        @(negedge clock);
        check("lu_r0_pc_write", int'(hif.pc_write), 1);
        step();
        clearInputs();
        @(negedge clock);
        check("lu_r0_stall", int'(hif.stall_cycles), 1);

        // Branch beats load-use
        doReset();
        hif.idex_mem_read = 1'b1; hif.idex_rt = 5'd7; hif.ifid_rt = 5'd7; hif.pcsrc = 1'b1;
        @(negedge clock);
        check("br_flushes", int'({hif.ifid_flush, hif.idex_flush, hif.exmem_flush}), 7);
        check("br_pc_write", int'(hif.pc_write), 1);
        check("br_hazard_mux", int'(hif.hazard_mux), 0);
        step();
        clearInputs();
        @(negedge clock);
        check("br_flush_count", int'(hif.flush_count), 1);
        check("br_stall", int'(hif.stall_cycles), 0);

        // Memory wait: 4 frozen cycles then release
        doReset();
        hif.exmem_mem_access = 1'b1; hif.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("mw_hold", int'(hif.pipe_hold), 1);
            step();
        end
        hif.mem_ready = 1'b1;
        @(negedge clock);
        check("mw_release_hold", int'(hif.pipe_hold), 0);
        check("mw_release_pc", int'(hif.pc_write), 1);
        step();
        clearInputs();
        @(negedge clock);
        check("mw_stall", int'(hif.stall_cycles), 4);

        // Timeout: 5 frozen cycles, then hung
        doReset();
        hif.exmem_mem_access = 1'b1; hif.mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("to_hold", int'(hif.pipe_hold), 1);
            step();
        end
        @(negedge clock);
        check("to_flag", int'(hif.mem_timeout), 1);
        hif.mem_ready = 1'b1; hif.pcsrc = 1'b1;
        @(negedge clock);
        check("to_err_pc", int'(hif.pc_write), 0);
        check("to_err_flush", int'(hif.ifid_flush), 0);
        step();
        @(negedge clock);
        check("to_sticky", int'(hif.mem_timeout), 1);
        check("to_stall", int'(hif.stall_cycles), 7);
        doReset();
        @(negedge clock);
        check("to_cleared", int'(hif.mem_timeout), 0);
        check("to_run_pc", int'(hif.pc_write), 1);

        // Branch held during freeze is applied at release
        doReset();
        hif.exmem_mem_access = 1'b1; hif.mem_ready = 1'b0; hif.pcsrc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("bf_no_flush", int'(hif.ifid_flush), 0);
            step();
        end
        hif.mem_ready = 1'b1;
        @(negedge clock);
        check("bf_release_flush", int'({hif.ifid_flush, hif.exmem_flush}), 3);
        step();
        clearInputs();
        @(negedge clock);
        check("bf_flush_count", int'(hif.flush_count), 1);

        // Saturation: 20 load-use cycles on a 4-bit counter
        doReset();
        hif.idex_mem_read = 1'b1; hif.idex_rt = 5'd9; hif.ifid_rs = 5'd9;
        for (int i = 0; i < 20; i++) step();
        clearInputs();
        @(negedge clock);
        check("sat_stall", int'(hif.stall_cycles), 15);

        // Randomized traffic checked by the model every cycle
        doReset();
        busyLeft = 0;
        for (int i = 0; i < 3000; i++) begin
            reset             = ($urandom_range(0, 63) == 0);
            hif.idex_mem_read = 1'($urandom_range(0, 1));
            hif.idex_rt       = 5'($urandom_range(0, 3));
            hif.ifid_rs       = 5'($urandom_range(0, 3));
            hif.ifid_rt       = 5'($urandom_range(0, 3));
            hif.pcsrc         = ($urandom_range(0, 5) == 0);
            hif.exmem_mem_access = ($urandom_range(0, 2) == 0);
            if (busyLeft > 0) begin
                hif.mem_ready = 1'b0;
                busyLeft--;
            end else if (hif.exmem_mem_access && $urandom_range(0, 2) == 0) begin
                busyLeft      = $urandom_range(1, 7);
                hif.mem_ready = 1'b0;
            end else begin
                hif.mem_ready = 1'b1;
            end
            step();
        end
        reset = 1'b0;
        clearInputs();
        step();
        @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
